// File: rtl/streamload_pkg.sv
// streamload_pkg: register map, FSM state encoding and post-reset timing shared by the
// streamload DMA reader and its FIFO.
// Contents: REG_* register indices, state_t, POST_RESET_GUARD (cycles of read/return blocking).
package streamload_pkg;

  // CPU-visible register indices (addr_rel_i)
  localparam logic [1:0] REG_CTRL       = 2'd0;
  localparam logic [1:0] REG_BASE       = 2'd1;
  localparam logic [1:0] REG_FLOWLENGTH = 2'd2;
  localparam logic [1:0] REG_STATUS     = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reset wipes the pending counter, so beats already in flight when reset hit cannot be
  // counted off. The master instead refuses to issue reads and ignores readdatavalid for
  // this many cycles after reset deassertion.
  localparam int POST_RESET_GUARD = 16;
  localparam int GUARD_W          = $clog2(POST_RESET_GUARD + 1);

endpackage

// File: rtl/streamload_fifo.sv
// streamload_fifo: single-clock pixel buffer between the read-return path and the stream output.
// Latency: a pushed word can be popped the next cycle; dout is registered and valid the cycle after pop.
// Backpressure: push while full and pop while empty are ignored; the caller keeps both from happening.
// Ports: clk, rst (async active-high), push/din, pop/dout, empty, full, count (0..FIFODEPTH).
module streamload_fifo #(
  parameter  int DATAWIDTH = 8,
  parameter  int FIFODEPTH = 1024,
  localparam int AW        = $clog2(FIFODEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAWIDTH-1:0] din,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 empty,
  output logic                 full,
  output logic [CW-1:0]        count
);

  logic [DATAWIDTH-1:0] mem [FIFODEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFODEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFODEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/streamload.sv
// streamload: memory-to-stream DMA reader; fetches FLOWLENGTH pixels from BASE over an Avalon-MM
//   pipelined read master and emits them as a data/dv/sop/eop pixel stream, then pulses irq_done.
// Latency: first out_dv 2 cycles after the first readdatavalid; 1 pixel/cycle once data flows.
// Backpressure: reads are issued only while buffered + outstanding pixels < FIFODEPTH, so the FIFO
//   never overflows; address/read are held during waitrequest; the stream side has no ready.
// Ports: clk_proc/reset; out_* pixel stream; master_* read master; addr_rel_i/wr_i/datawr_i/rd_i/datard_o
//   CPU register slave (CTRL, BASE, FLOWLENGTH, STATUS); irq_done frame-complete pulse.
module streamload
  import streamload_pkg::*;
#(
  parameter int          DATAWIDTH          = 8,
  parameter int          FIFODEPTH          = 1024,
  parameter int          ADDRESSWIDTH       = 32,
  parameter logic [31:0] DEFAULT_FLOWLENGTH = 32'd0
) (
  input  logic                    clk_proc,
  input  logic                    reset,
  output logic [DATAWIDTH-1:0]    out_data,
  output logic                    out_dv,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic                    master_read,
  input  logic [DATAWIDTH-1:0]    master_readdata,
  input  logic                    master_readdatavalid,
  input  logic                    master_waitrequest,
  input  logic [1:0]              addr_rel_i,
  input  logic                    wr_i,
  input  logic [31:0]             datawr_i,
  input  logic                    rd_i,
  output logic [31:0]             datard_o,
  output logic                    irq_done
);

  localparam int CW = $clog2(FIFODEPTH) + 1;

  state_t                  state;
  state_t                  next_state;

  logic [ADDRESSWIDTH-1:0] base_reg;
  logic [31:0]             len_reg;
  logic                    done_sticky;

  // Working copies latched at start so CPU writes cannot disturb a running frame.
  logic [ADDRESSWIDTH-1:0] work_base;
  logic [31:0]             work_len;
  logic [31:0]             req_cnt;
  logic [31:0]             out_cnt;
  logic [CW-1:0]           pending;
  logic [GUARD_W-1:0]      guard_cnt;

  logic                    busy;
  logic                    start;
  logic                    load;
  logic                    zero_done;
  logic                    frame_done;
  logic                    guard_active;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    credit_ok;
  logic [CW:0]             inflight;

  logic [DATAWIDTH-1:0]    fifo_dout;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [CW-1:0]           fifo_count;

  assign busy         = (state != IDLE);
  assign start        = wr_i && (addr_rel_i == REG_CTRL) && datawr_i[0];
  assign guard_active = (guard_cnt != '0);

  // Every accepted read owns a FIFO slot until its pixel is popped: it is either still
  // outstanding (pending) or already buffered (fifo_count).
  assign inflight  = (CW+1)'(fifo_count) + (CW+1)'(pending);
  assign credit_ok = (inflight < (CW+1)'(FIFODEPTH));

  assign accept = master_read && !master_waitrequest;
  // fifo_full cannot be seen with a legal return because of the credit check above.
  assign push   = master_readdatavalid && !guard_active && !fifo_full;
  assign pop    = !fifo_empty;

  // Modulo-2^ADDRESSWIDTH arithmetic; wrap past the top is allowed.
  assign master_address = work_base + ADDRESSWIDTH'(req_cnt);
  assign out_data       = fifo_dout;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_proc or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    master_read = 1'b0;
    load        = 1'b0;
    zero_done   = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_reg != '0) begin
            load       = 1'b1;
            next_state = READ;
          end else begin
            zero_done  = 1'b1;
          end
        end
      end
      READ: begin
        // Counters only move on accept and the credit sum cannot grow during a stall,
        // so read and address stay put while waitrequest is high.
        master_read = !guard_active && (req_cnt < work_len) && credit_ok;
        if (accept && (req_cnt == work_len - 32'd1)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (out_cnt == work_len) begin
          next_state = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk_proc or posedge reset) begin
    if (reset) begin
      work_base <= '0;
      work_len  <= '0;
      req_cnt   <= '0;
      out_cnt   <= '0;
      pending   <= '0;
      guard_cnt <= GUARD_W'(POST_RESET_GUARD);
    end else begin
      if (guard_active) begin
        guard_cnt <= guard_cnt - 1'b1;
      end
      if (load) begin
        work_base <= base_reg;
        work_len  <= len_reg;
        req_cnt   <= '0;
        out_cnt   <= '0;
        pending   <= '0;
      end else begin
        if (accept) begin
          req_cnt <= req_cnt + 32'd1;
        end
        if (pop) begin
          out_cnt <= out_cnt + 32'd1;
        end
        if (accept && !push) begin
          pending <= pending + 1'b1;
        end else if (push && !accept) begin
          pending <= pending - 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- output stage
  // Flags are computed from out_cnt at pop time and registered alongside the FIFO dout,
  // so they line up with the pixel they describe.
  always_ff @(posedge clk_proc or posedge reset) begin
    if (reset) begin
      out_dv   <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      irq_done <= 1'b0;
    end else begin
      out_dv   <= pop;
      out_sop  <= pop && (out_cnt == '0);
      out_eop  <= pop && (out_cnt == work_len - 32'd1);
      irq_done <= frame_done || zero_done;
    end
  end

  // ---------------------------------------------------------------- register slave
  always_ff @(posedge clk_proc or posedge reset) begin
    if (reset) begin
      base_reg    <= '0;
      len_reg     <= DEFAULT_FLOWLENGTH;
      done_sticky <= 1'b0;
      datard_o    <= '0;
    end else begin
      if (wr_i && !busy) begin
        if (addr_rel_i == REG_BASE) begin
          base_reg <= ADDRESSWIDTH'(datawr_i);
        end
        if (addr_rel_i == REG_FLOWLENGTH) begin
          len_reg <= datawr_i;
        end
      end
      if (rd_i) begin
        case (addr_rel_i)
          REG_CTRL:       datard_o <= {30'b0, done_sticky, busy};
          REG_BASE:       datard_o <= 32'(base_reg);
          REG_FLOWLENGTH: datard_o <= len_reg;
          REG_STATUS:     datard_o <= out_cnt;
        endcase
      end
      // A completion landing on the same cycle as a CTRL read must not be lost.
      if (frame_done || zero_done) begin
        done_sticky <= 1'b1;
      end else if (rd_i && (addr_rel_i == REG_CTRL)) begin
        done_sticky <= 1'b0;
      end
    end
  end

  streamload_fifo #(
    .DATAWIDTH (DATAWIDTH),
    .FIFODEPTH (FIFODEPTH)
  ) u_fifo (
    .clk   (clk_proc),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (master_readdata),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_streamload.sv
// tb_streamload: scoreboard bench for streamload with a small FIFO so credit limiting is exercised.
// A memory model with programmable latency and waitrequest patterns answers reads with addr[7:0];
// expected pixels are queued from (BASE + i) when a frame is started and popped by a separate monitor.
module tb_streamload;
  import streamload_pkg::*;

  localparam int DW = 8;
  localparam int FD = 4;
  localparam int AW = 32;

  logic          clk_proc;
  logic          reset;
  logic [DW-1:0] out_data;
  logic          out_dv, out_sop, out_eop;
  logic [AW-1:0] master_address;
  logic          master_read;
  logic [DW-1:0] master_readdata;
  logic          master_readdatavalid, master_waitrequest;
  logic [1:0]    addr_rel_i;
  logic          wr_i, rd_i;
  logic [31:0]   datawr_i, datard_o;
  logic          irq_done;

  streamload #(
    .DATAWIDTH(DW), .FIFODEPTH(FD), .ADDRESSWIDTH(AW), .DEFAULT_FLOWLENGTH(32'd0)
  ) dut (
    .clk_proc(clk_proc), .reset(reset),
    .out_data(out_data), .out_dv(out_dv), .out_sop(out_sop), .out_eop(out_eop),
    .master_address(master_address), .master_read(master_read),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .addr_rel_i(addr_rel_i), .wr_i(wr_i), .datawr_i(datawr_i), .rd_i(rd_i),
    .datard_o(datard_o), .irq_done(irq_done)
  );

  typedef struct packed { logic [7:0] data; logic sop; logic eop; } pix_t;
  typedef struct packed { int unsigned due; logic [7:0] data; } rsp_t;

  pix_t exp_q[$];
  rsp_t mem_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int lat = 1;
  int stall_mode = 0;  // 0 none, 1 every third cycle, 2 random
  int unsigned cyc = 0;
  int irq_cnt = 0;
  int pix_seen = 0;
  int acc_total = 0;
  int acc_ever = 0;
  int dv_total = 0;

  initial begin
    clk_proc = 1'b0;
    forever #5 clk_proc = ~clk_proc;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ memory model
  initial begin : mem_model
    logic        prev_stall;
    logic [31:0] prev_addr;
    rsp_t        r;
    prev_stall = 1'b0;
    prev_addr  = '0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    master_waitrequest   = 1'b0;
    forever begin
      @(negedge clk_proc);
      cyc++;
      if (reset) begin
        acc_total  = 0;
        dv_total   = 0;
        prev_stall = 1'b0;
      end else if (out_dv) begin
        dv_total++;
      end
      // In-flight beats keep returning across a reset to model stale data.
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        r = mem_q.pop_front();
        master_readdatavalid = 1'b1;
        master_readdata      = r.data;
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata      = DW'($urandom);
      end
      case (stall_mode)
        1:       master_waitrequest = (cyc % 3 == 0);
        2:       master_waitrequest = ($urandom_range(0, 9) < 3);
        default: master_waitrequest = 1'b0;
      endcase
      if (!reset) begin
        if (prev_stall) begin
          check("addr_hold_during_stall", {master_read, master_address}, {1'b1, prev_addr});
        end
        prev_stall = master_read && master_waitrequest;
        prev_addr  = master_address;
        if (master_read && !master_waitrequest) begin
          acc_total++;
          acc_ever++;
          r.due  = cyc + lat;
          r.data = master_address[7:0];
          mem_q.push_back(r);
          check("outstanding_plus_buffered_le_depth", (acc_total - dv_total) <= FD, 1'b1);
        end
      end
    end
  end

  // ------------------------------------------------------------ output monitor
  initial begin : monitor
    pix_t e;
    logic have;
    forever begin
      @(negedge clk_proc);
      if (!reset) begin
        if (irq_done) irq_cnt++;
        if (out_dv) begin
          have = (exp_q.size() != 0);
          e = '0;
          if (have) e = exp_q.pop_front();
          pix_seen++;
          check("pixel_was_expected", have, 1'b1);
          check("pixel_data_sop_eop", {out_data, out_sop, out_eop}, e);
        end else begin
          check("sop_eop_without_dv", {out_sop, out_eop}, 2'b00);
        end
      end
    end
  end

  // ------------------------------------------------------------ CPU tasks
  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk_proc);
    addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
    @(negedge clk_proc);
    wr_i = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk_proc);
    addr_rel_i = a; rd_i = 1'b1;
    @(negedge clk_proc);
    rd_i = 1'b0;
    d = datard_o;
  endtask

  // Reference: pixel i of a frame is the low byte of BASE+i, sop on i=0, eop on i=len-1.
  task automatic expect_frame(input logic [31:0] base, input int len);
    pix_t p;
    logic [31:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 32'(i);
      p.data = a[7:0];
      p.sop  = (i == 0);
      p.eop  = (i == len - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic wait_irq(input string name, input int irq0);
    int n = 0;
    while (irq_cnt == irq0 && n < 20000) begin
      @(negedge clk_proc);
      n++;
    end
    check({name, "_irq_seen"}, irq_cnt != irq0, 1'b1);
    repeat (4) @(negedge clk_proc);
    check({name, "_irq_single_pulse"}, 64'(irq_cnt - irq0), 64'd1);
    check({name, "_all_pixels_emitted"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic frame(input string name, input logic [31:0] base, input int len);
    int irq0;
    logic [31:0] r;
    reg_write(REG_BASE, base);
    reg_write(REG_FLOWLENGTH, 32'(len));
    expect_frame(base, len);
    irq0 = irq_cnt;
    reg_write(REG_CTRL, 32'd1);
    wait_irq(name, irq0);
    reg_read(REG_CTRL, r);
    check({name, "_ctrl_done"}, r, 64'd2);
    reg_read(REG_CTRL, r);
    check({name, "_ctrl_cleared"}, r, 64'd0);
  endtask

  // ------------------------------------------------------------ main sequence
  initial begin : main
    logic [31:0] r;
    int irq0, acc0, p0, n, len;
    logic [31:0] base;
    wr_i = 1'b0; rd_i = 1'b0; addr_rel_i = '0; datawr_i = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk_proc);
    check("reset_stream_outputs", {out_data, out_dv, out_sop, out_eop, irq_done}, '0);
    check("reset_master_outputs", {master_read, master_address}, '0);
    check("reset_datard", datard_o, '0);
    reset = 1'b0;
    repeat (20) @(negedge clk_proc);
    reg_read(REG_FLOWLENGTH, r); check("reset_flowlength", r, 64'd0);
    reg_read(REG_BASE, r);       check("reset_base", r, 64'd0);
    reg_read(REG_CTRL, r);       check("reset_ctrl", r, 64'd0);

    // Fast memory, no stalls.
    lat = 1; stall_mode = 0;
    frame("frame_fast", 32'h1000, 320);
    reg_read(REG_STATUS, r); check("status_after_frame", r, 64'd320);

    // Stalls every third cycle with 5-cycle latency.
    lat = 5; stall_mode = 1;
    frame("frame_stall", 32'h1000, 320);

    // Memory latency well beyond the FIFO depth.
    lat = 10; stall_mode = 0;
    frame("frame_lat10", 32'h1000, 320);

    // Single pixel: sop and eop together.
    lat = 3;
    frame("frame_len1", 32'h0000_00AB, 1);

    // Zero length: no reads, one irq.
    acc0 = acc_ever;
    frame("frame_len0", 32'h4000, 0);
    check("len0_no_reads", 64'(acc_ever - acc0), 64'd0);

    // Address wrap past the top of the address space.
    lat = 2; stall_mode = 2;
    frame("frame_wrap", 32'hFFFF_FFF0, 32);

    // Randomized frames.
    for (int k = 0; k < 4; k++) begin
      lat = $urandom_range(1, 12);
      stall_mode = $urandom_range(0, 2);
      base = $urandom;
      len = $urandom_range(1, 40);
      frame("frame_random", base, len);
    end

    // BASE/FLOWLENGTH writes and a second start during a busy frame are ignored.
    lat = 1; stall_mode = 0;
    reg_write(REG_BASE, 32'h3000);
    reg_write(REG_FLOWLENGTH, 32'd100);
    expect_frame(32'h3000, 100);
    irq0 = irq_cnt;
    reg_write(REG_CTRL, 32'd1);
    reg_read(REG_CTRL, r); check("busy_flag", r, 64'd1);
    reg_write(REG_BASE, 32'h5555);
    reg_write(REG_FLOWLENGTH, 32'd7);
    reg_write(REG_CTRL, 32'd1);
    wait_irq("frame_busy_writes", irq0);
    reg_read(REG_BASE, r);       check("base_write_ignored", r, 64'h3000);
    reg_read(REG_FLOWLENGTH, r); check("flowlength_write_ignored", r, 64'd100);
    reg_read(REG_CTRL, r);       check("busy_frame_ctrl_done", r, 64'd2);

    // Reset at pixel 100, then a fresh 50-pixel frame with stale returns in flight.
    lat = 5; stall_mode = 0;
    reg_write(REG_BASE, 32'h1000);
    reg_write(REG_FLOWLENGTH, 32'd320);
    expect_frame(32'h1000, 320);
    p0 = pix_seen;
    reg_write(REG_CTRL, 32'd1);
    n = 0;
    while (pix_seen - p0 < 100 && n < 5000) begin
      @(negedge clk_proc);
      n++;
    end
    check("reached_pixel_100", (pix_seen - p0) >= 100, 1'b1);
    @(posedge clk_proc);
    #2 reset = 1'b1;
    #1;
    check("midreset_stream_outputs", {out_data, out_dv, out_sop, out_eop, irq_done}, '0);
    check("midreset_master_outputs", {master_read, master_address}, '0);
    check("midreset_datard", datard_o, '0);
    exp_q.delete();
    repeat (2) @(negedge clk_proc);
    reset = 1'b0;
    reg_read(REG_FLOWLENGTH, r); check("midreset_flowlength", r, 64'd0);
    frame("frame_after_reset", 32'h2080, 50);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vec_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
